id_stage_pipelined: RTL and testbench

Parametrised, pipelined instruction-decode stage for the MIPS datapath. Accepts one 32-bit instruction per cycle over a valid/ready handshake. Reads a parametrised register file with writeback bypass and detects load-use hazards, which it resolves by stalling. Produces a registered decode bundle (operands, sign-extended immediate, destination register, control bits) for the execute stage.

---
 rtl/id_stage_pipelined.sv | 186 ++++++++++++++++++
 tb/tb_id_stage_pipelined.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipelined.sv
// Pipelined MIPS instruction-decode stage: register file with writeback bypass,
// load-use hazard stall, and a registered decode bundle behind a valid/ready handshake.
module id_stage_pipelined #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  input  logic [AW-1:0]     ex_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] extended_address,
  output logic [AW-1:0]     write_register,
  output logic              ctrl_reg_dest,
  output logic              ctrl_reg_write,
  output logic              ctrl_mem_read,
  output logic              ctrl_mem_write,
  output logic              ctrl_branch,
  output logic              illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic       ZERO_EN  = (ZERO_REG != 0);
  localparam logic [AW-1:0] REG0  = {AW{1'b0}};

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  logic [5:0]        op_s;
  logic [4:0]        rs_field_s, rt_field_s, rd_field_s;
  logic [AW-1:0]     rs_s, rt_s, rd_s;
  logic              wb_eff_s;
  logic              hazard_s;
  logic              advance_s;
  logic              load_s;
  logic              uses_rt_s;
  logic              dec_reg_dest_s, dec_reg_write_s, dec_mem_read_s;
  logic              dec_mem_write_s, dec_branch_s, dec_illegal_s;
  logic [DATA_W-1:0] opnd_1_s, opnd_2_s;
  logic [DATA_W-1:0] ext_s;
  logic [AW-1:0]     wreg_s;

  assign op_s       = instruction[31:26];
  assign rs_field_s = instruction[25:21];
  assign rt_field_s = instruction[20:16];
  assign rd_field_s = instruction[15:11];
  assign rs_s       = rs_field_s[AW-1:0];
  assign rt_s       = rt_field_s[AW-1:0];
  assign rd_s       = rd_field_s[AW-1:0];
  assign ext_s      = DATA_W'($signed(instruction[15:0]));

  // Writes to the hard-wired zero register are discarded before they can bypass or land.
  assign wb_eff_s  = wb_en & ~(ZERO_EN & (wb_addr == REG0));
  assign advance_s = out_ready | ~out_valid;
  assign hazard_s  = ex_mem_read & ((ex_rd != REG0) | ~ZERO_EN) & in_valid &
                     ((ex_rd == rs_s) | (uses_rt_s & (ex_rd == rt_s)));
  assign in_ready  = advance_s & ~hazard_s & ~flush;
  assign load_s    = advance_s & in_valid & ~hazard_s;

  // Opcode decode into control bits
  always_comb begin
    dec_reg_dest_s  = 1'b0;
    dec_reg_write_s = 1'b0;
    dec_mem_read_s  = 1'b0;
    dec_mem_write_s = 1'b0;
    dec_branch_s    = 1'b0;
    dec_illegal_s   = 1'b0;
    uses_rt_s       = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        dec_reg_dest_s  = 1'b1;
        dec_reg_write_s = 1'b1;
        uses_rt_s       = 1'b1;
      end
      OP_LW: begin
        dec_reg_write_s = 1'b1;
        dec_mem_read_s  = 1'b1;
      end
      OP_SW: begin
        dec_mem_write_s = 1'b1;
        uses_rt_s       = 1'b1;
      end
      OP_BEQ: begin
        dec_branch_s = 1'b1;
        uses_rt_s    = 1'b1;
      end
      OP_ADDI: begin
        dec_reg_write_s = 1'b1;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // Destination register select
  always_comb begin
    if (dec_reg_dest_s) begin
      wreg_s = rd_s;
    end else begin
      wreg_s = rt_s;
    end
  end

  // Operand read with write-before-read bypass from the writeback port
  always_comb begin
    if (ZERO_EN && (rs_s == REG0)) begin
      opnd_1_s = {DATA_W{1'b0}};
    end else if (wb_eff_s && (wb_addr == rs_s)) begin
      opnd_1_s = wb_data;
    end else begin
      opnd_1_s = regs_r[rs_s];
    end
    if (ZERO_EN && (rt_s == REG0)) begin
      opnd_2_s = {DATA_W{1'b0}};
    end else if (wb_eff_s && (wb_addr == rt_s)) begin
      opnd_2_s = wb_data;
    end else begin
      opnd_2_s = regs_r[rt_s];
    end
  end

  // Register file array
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_eff_s) begin
      regs_r[wb_addr] <= wb_data;
    end else begin
      regs_r[wb_addr] <= regs_r[wb_addr];
    end
  end

  // Decode bundle output register; holds while stalled by the execute stage
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid        <= 1'b0;
      read_data_1      <= {DATA_W{1'b0}};
      read_data_2      <= {DATA_W{1'b0}};
      extended_address <= {DATA_W{1'b0}};
      write_register   <= REG0;
      ctrl_reg_dest    <= 1'b0;
      ctrl_reg_write   <= 1'b0;
      ctrl_mem_read    <= 1'b0;
      ctrl_mem_write   <= 1'b0;
      ctrl_branch      <= 1'b0;
      illegal          <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_s) begin
      out_valid        <= 1'b1;
      read_data_1      <= opnd_1_s;
      read_data_2      <= opnd_2_s;
      extended_address <= ext_s;
      write_register   <= wreg_s;
      ctrl_reg_dest    <= dec_reg_dest_s;
      ctrl_reg_write   <= dec_reg_write_s;
      ctrl_mem_read    <= dec_mem_read_s;
      ctrl_mem_write   <= dec_mem_write_s;
      ctrl_branch      <= dec_branch_s;
      illegal          <= dec_illegal_s;
    end else if (advance_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed, table-driven bench for id_stage_pipelined (DATA_W=32, NUM_REGS=32, ZERO_REG=1).
module tb_id_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, wb_en, ex_mem_read, flush, out_valid, out_ready;
  logic [31:0] instruction, wb_data, read_data_1, read_data_2, extended_address;
  logic [4:0]  wb_addr, ex_rd, write_register;
  logic        ctrl_reg_dest, ctrl_reg_write, ctrl_mem_read, ctrl_mem_write, ctrl_branch, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage_pipelined #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .extended_address(extended_address), .write_register(write_register),
    .ctrl_reg_dest(ctrl_reg_dest), .ctrl_reg_write(ctrl_reg_write),
    .ctrl_mem_read(ctrl_mem_read), .ctrl_mem_write(ctrl_mem_write),
    .ctrl_branch(ctrl_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // ctrl packing: {reg_dest, reg_write, mem_read, mem_write, branch, illegal}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_ext;
    logic [4:0]  exp_wreg;
    logic [5:0]  exp_ctrl;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; instruction = 32'h0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    idle_inputs();
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  function automatic logic [5:0] ctrl_now();
    return {ctrl_reg_dest, ctrl_reg_write, ctrl_mem_read, ctrl_mem_write, ctrl_branch, illegal};
  endfunction

  logic [31:0] held_rd1, held_rd2;
  logic [4:0]  held_wreg;

  initial begin
    vecs[0] = '{"add_r",    32'h00221820, 1'b0, 5'd0, 32'h0,  32'd5,  32'd7,  32'h00001820, 5'd3,  6'b110000};
    vecs[1] = '{"addi_neg", 32'h2029FFFC, 1'b0, 5'd0, 32'h0,  32'd5,  32'd0,  32'hFFFFFFFC, 5'd9,  6'b010000};
    vecs[2] = '{"bypass",   32'h00225020, 1'b1, 5'd1, 32'hAA, 32'hAA, 32'd7,  32'h00005020, 5'd10, 6'b110000};
    vecs[3] = '{"zero_reg", 32'h00005820, 1'b1, 5'd0, 32'h55, 32'd0,  32'd0,  32'h00005820, 5'd11, 6'b110000};
    vecs[4] = '{"lw",       32'h8D0C8000, 1'b0, 5'd0, 32'h0,  32'h1234, 32'd0, 32'hFFFF8000, 5'd12, 6'b011000};
    vecs[5] = '{"sw",       32'hAC220004, 1'b0, 5'd0, 32'h0,  32'hAA, 32'd7,  32'h00000004, 5'd2,  6'b000100};
    vecs[6] = '{"beq",      32'h10867FFF, 1'b0, 5'd0, 32'h0,  32'h40, 32'h60, 32'h00007FFF, 5'd6,  6'b000010};
    vecs[7] = '{"illegal",  32'hFC221820, 1'b0, 5'd0, 32'h0,  32'hAA, 32'd7,  32'h00001820, 5'd2,  6'b000001};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_rd1", read_data_1, 32'd0);
    chk("reset_ctrl", {26'd0, ctrl_now()}, 32'd0);
    reset = 1'b0;

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    wb_write(5'd4, 32'h40);
    wb_write(5'd6, 32'h60);
    wb_write(5'd8, 32'h1234);

    // Back-to-back table vectors at full throughput
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      in_valid = 1'b1; instruction = vecs[i].instr;
      wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
      #1;
      chk({vecs[i].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      chk({vecs[i].name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[i].name, "_rd1"}, read_data_1, vecs[i].exp_rd1);
      chk({vecs[i].name, "_rd2"}, read_data_2, vecs[i].exp_rd2);
      chk({vecs[i].name, "_ext"}, extended_address, vecs[i].exp_ext);
      chk({vecs[i].name, "_wreg"}, {27'd0, write_register}, {27'd0, vecs[i].exp_wreg});
      chk({vecs[i].name, "_ctrl"}, {26'd0, ctrl_now()}, {26'd0, vecs[i].exp_ctrl});
    end

    // Load-use hazard on rs: one bubble, then accept
    idle_inputs();
    in_valid = 1'b1; instruction = 32'h00862820; ex_mem_read = 1'b1; ex_rd = 5'd4;
    #1;
    chk("hazard_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("hazard_bubble", {31'd0, out_valid}, 32'd0);
    ex_mem_read = 1'b0;
    #1;
    chk("hazard_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("hazard_accept_valid", {31'd0, out_valid}, 32'd1);
    chk("hazard_accept_rd1", read_data_1, 32'h40);
    chk("hazard_accept_rd2", read_data_2, 32'h60);
    chk("hazard_accept_wreg", {27'd0, write_register}, 32'd5);

    // Load target equals addi rt: rt unused, so no hazard
    instruction = 32'h2029FFFC; ex_mem_read = 1'b1; ex_rd = 5'd9;
    #1;
    chk("addi_rt_no_hazard", {31'd0, in_ready}, 32'd1);
    // Load into $0 never stalls
    instruction = 32'h00005820; ex_rd = 5'd0;
    #1;
    chk("ex_rd0_no_hazard", {31'd0, in_ready}, 32'd1);
    ex_mem_read = 1'b0;

    // Backpressure: bundle from add $3,$1,$2 held for 3 cycles
    instruction = 32'h00221820;
    tick();
    held_rd1 = 32'hAA; held_rd2 = 32'd7; held_wreg = 5'd3;
    out_ready = 1'b0; instruction = 32'h10867FFF; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_rd1_held", read_data_1, held_rd1);
      chk("bp_rd2_held", read_data_2, held_rd2);
      chk("bp_wreg_held", {27'd0, write_register}, {27'd0, held_wreg});
    end
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; out_ready = 1'b1;

    // Reset during backpressure clears the bundle and the register file
    instruction = 32'h00221820;
    tick();
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b0; reset = 1'b1;
    tick();
    chk("reset_bp_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    tick();
    chk("post_reset_accept", {31'd0, out_valid}, 32'd1);
    chk("post_reset_rf_rd1", read_data_1, 32'd0);
    chk("post_reset_rf_rd2", read_data_2, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
